// File: rtl/clock_divider_prog.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : clock_divider_prog                                       |
// | Description : Runtime-programmable clock divider / tick generator.     |
// |               Divides clk by N (loaded via div_load/div_value), and    |
// |               produces a 50% duty divided clock of period 2N plus a    |
// |               one-cycle tick strobe every N enabled cycles.            |
// |               Optional macro CLKDIV_IMMEDIATE_LOAD_EN: a load takes    |
// |               effect on the load edge (counter and clk_out restart)    |
// |               instead of waiting for the next wrap.                    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module clock_divider_prog #(
   parameter int unsigned      WIDTH       = 27,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50_000_000)
) (
   input  logic             clk,
   input  logic             rst,        // asynchronous, active low
   input  logic             en,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_value,
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);

   localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);
   // A zero default divisor would never wrap; clamp it like a runtime load.
   localparam logic [WIDTH-1:0] c_RESET_DIV = (DEFAULT_DIV == '0) ? c_ONE : DEFAULT_DIV;

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div_act;
   logic             r_clk_out;
   logic             r_tick;

   logic [WIDTH-1:0] w_div_new;
   logic [WIDTH-1:0] w_cnt_last;
   logic             w_wrap;

   // Divisor 0 is treated as 1 so the counter always has a reachable terminal value.
   assign w_div_new  = (div_value == '0) ? c_ONE : div_value;
   // Terminal count; r_div_act is never 0, so this never underflows.
   assign w_cnt_last = r_div_act - c_ONE;
   // Wrap happens only on an enabled cycle at the terminal count.
   assign w_wrap     = en & (r_cnt == w_cnt_last);

`ifdef CLKDIV_IMMEDIATE_LOAD_EN

   // Counter: restarts on a load, otherwise counts enabled cycles up to N-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (div_load) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + c_ONE;
      end
   end

   // Tick strobe: one cycle at each wrap, suppressed on the load edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tick <= 1'b0;
      end else if (div_load) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap;
      end
   end

   // Divided clock: forced low on a load so the new period starts cleanly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clk_out <= 1'b0;
      end else if (div_load) begin
         r_clk_out <= 1'b0;
      end else if (w_wrap) begin
         r_clk_out <= ~r_clk_out;
      end
   end

   // Active divisor: replaced directly on the load edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div_act <= c_RESET_DIV;
      end else if (div_load) begin
         r_div_act <= w_div_new;
      end
   end

   // No deferred load exists in this build.
   assign pending = 1'b0;

`else

   logic [WIDTH-1:0] r_div_shadow;
   logic             r_pending;

   // Counter: counts enabled cycles 0..N-1 and holds while en is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + c_ONE;
      end
   end

   // Tick strobe: one cycle at each wrap; w_wrap already includes en.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap;
      end
   end

   // Divided clock: toggles on every wrap, giving N-cycle high and low phases.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clk_out <= 1'b0;
      end else if (w_wrap) begin
         r_clk_out <= ~r_clk_out;
      end
   end

   // Shadow divisor: captures every load (last one wins), even while disabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div_shadow <= c_RESET_DIV;
      end else if (div_load) begin
         r_div_shadow <= w_div_new;
      end
   end

   // Pending flag: set by a load between wraps, cleared when a wrap consumes it.
   // A load coincident with a wrap is consumed at once and never sets it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pending <= 1'b0;
      end else if (w_wrap) begin
         r_pending <= 1'b0;
      end else if (div_load) begin
         r_pending <= 1'b1;
      end
   end

   // Active divisor: swapped only at a wrap so clk_out never gets a runt phase.
   // A same-cycle load takes priority over an older pending shadow value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div_act <= c_RESET_DIV;
      end else if (w_wrap) begin
         if (div_load) begin
            r_div_act <= w_div_new;
         end else if (r_pending) begin
            r_div_act <= r_div_shadow;
         end
      end
   end

   assign pending = r_pending;

`endif

   assign clk_out = r_clk_out;
   assign tick    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_clock_divider_prog                                    |
// | Description : Self-checking bench for clock_divider_prog (WIDTH=8,     |
// |               DEFAULT_DIV=4). Expected outputs per edge are queued     |
// |               with the stimulus and compared after the edge.           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_clock_divider_prog;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         en;
   logic         div_load;
   logic [W-1:0] div_value;
   logic         clk_out;
   logic         tick;
   logic         pending;

   int n_checks;
   int n_fails;
   int step_no;

   // Expected {tick, clk_out, pending} after the upcoming edge.
   logic [2:0] exp_q[$];

   clock_divider_prog #(
      .WIDTH       (W),
      .DEFAULT_DIV (8'd4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .div_load  (div_load),
      .div_value (div_value),
      .clk_out   (clk_out),
      .tick      (tick),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive inputs, queue expectation, take one rising edge,
   // compare just after it, then return at the following negedge.
   task automatic step(input logic e, input logic ld, input logic [W-1:0] v,
                       input logic et, input logic ec, input logic ep);
      logic [2:0] x;
      en        = e;
      div_load  = ld;
      div_value = v;
      exp_q.push_back({et, ec, ep});
      @(posedge clk);
      #1;
      step_no++;
      x = exp_q.pop_front();
      check($sformatf("tick@%0d", step_no),    tick,    x[2]);
      check($sformatf("clk_out@%0d", step_no), clk_out, x[1]);
      check($sformatf("pending@%0d", step_no), pending, x[0]);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      step_no   = 0;
      rst       = 1'b1;
      en        = 1'b0;
      div_load  = 1'b0;
      div_value = '0;

      // Reset state
      #2 rst = 1'b0;
      #1;
      check("reset_tick",    tick,    1'b0);
      check("reset_clk_out", clk_out, 1'b0);
      check("reset_pending", pending, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Default N=4: tick at edges 4,8,12; clk_out 0 (1-3), 1 (4-7), 0 (8-11), 1 (12)
      for (int k = 1; k <= 12; k++)
         step(1'b1, 1'b0, '0, (k % 4) == 0, ((k / 4) % 2) == 1, 1'b0);

`ifdef CLKDIV_IMMEDIATE_LOAD_EN
      // Load 6 restarts count and forces clk_out low, then load 2 at cnt=3.
      step(1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
      for (int k = 2; k <= 4; k++)
         step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
`else
      // Move to N=5: load while cnt=0, takes effect at the wrap on the 4th edge.
      step(1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, '0,   1'b1, 1'b0, 1'b0);

      // Load 3 at cnt=1 with N=5: ticks at 5,8,11; half-periods 5 then 3.
      for (int e = 1; e <= 11; e++)
         step(1'b1, e == 2, 8'd3,
              (e == 5) || (e == 8) || (e == 11),
              ((e >= 5) && (e < 8)) || (e >= 11),
              (e >= 2) && (e <= 4));

      // Load 0 behaves as N=1: after the wrap, tick stays high, clk_out toggles each edge.
      step(1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b1);
      for (int e = 3; e <= 10; e++)
         step(1'b1, 1'b0, '0, 1'b1, (e % 2) == 0, 1'b0);

      // Load 4 coincident with a wrap: applied at once, pending never rises.
      step(1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0,   1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0,   1'b0, 1'b0, 1'b0);
      // Disable 7 cycles at cnt=2: everything holds, tick stays low.
      for (int e = 4; e <= 10; e++)
         step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      // Next tick after 2 enabled cycles, then every 4.
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      for (int e = 13; e <= 15; e++)
         step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Get clk_out high, then load 7 while disabled (still captured).
      step(1'b1, 1'b0, '0,   1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0,   1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0,   1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0,   1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b1);

      // Asynchronous reset mid-count with a load pending.
      #2 rst = 1'b0;
      #1;
      check("async_rst_tick",    tick,    1'b0);
      check("async_rst_clk_out", clk_out, 1'b0);
      check("async_rst_pending", pending, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Back to DEFAULT_DIV=4, pending load discarded.
      for (int k = 1; k <= 8; k++)
         step(1'b1, 1'b0, '0, (k % 4) == 0, ((k / 4) % 2) == 1, 1'b0);
`endif

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
